abs_modulation_sequencer: RTL

- Sequences the brake actuator for the ABS path.
- Arbitrates between three sources: driver pedal, obstacle-detection emergency request, and anti-lock apply/release modulation.
- Produces the single brake_signal drive.
- Sits between the pedal/obstacle/wheel-speed sensor inputs and the brake actuator, in place of a plain pedal-to-brake path.

---
 rtl/abs_modulation_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/abs_modulation_sequencer.sv
// ABS brake sequencer: arbitrates pedal, obstacle emergency stop and anti-lock
// apply/release modulation onto a single registered brake drive.
module abs_modulation_sequencer #(
   parameter int unsigned LOCK_THRESH    = 20,
   parameter int unsigned DECEL_LIMIT    = 8,
   parameter int unsigned STOP_SPEED     = 2,
   parameter int unsigned APPLY_CYCLES   = 4,
   parameter int unsigned RELEASE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       brake_pedal,
   input  logic       Object_detected,
   input  logic [7:0] wheel_speed,
   input  logic       sample_valid,
   output logic       brake_signal,
   output logic       abs_active,
   output logic [7:0] abs_cycles,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StApply     = 3'd1,
      StRelease   = 3'd2,
      StEmergency = 3'd3,
      StStopped   = 3'd4
   } state_e;

   localparam logic [7:0] LockThresh   = 8'(LOCK_THRESH);
   localparam logic [7:0] DecelLimit   = 8'(DECEL_LIMIT);
   localparam logic [7:0] StopSpeed    = 8'(STOP_SPEED);
   localparam logic [7:0] ApplyLast    = 8'(APPLY_CYCLES - 1);
   localparam logic [7:0] ReleaseLast  = 8'(RELEASE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] speed_q, prev_q;
   logic [7:0] drop;
   logic       slip, stopped;
   logic       brake_q, brake_d;
   logic       active_q, active_d;
   logic [7:0] cycles_q, cycles_d;

   // prev/speed hold together between strobes, so the drop between the last two
   // samples can be formed from them instead of a third register.
   assign drop    = (prev_q > speed_q) ? prev_q - speed_q : 8'd0;
   assign slip    = (speed_q < LockThresh) || (drop >= DecelLimit);
   assign stopped = (speed_q <= StopSpeed);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         phase_q  <= 8'd0;
         speed_q  <= 8'hff;
         prev_q   <= 8'hff;
         brake_q  <= 1'b0;
         active_q <= 1'b0;
         cycles_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         brake_q  <= brake_d;
         active_q <= active_d;
         cycles_q <= cycles_d;
         if (sample_valid) begin
            prev_q  <= speed_q;
            speed_q <= wheel_speed;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      unique case (state_q)
         StIdle: begin
            if (Object_detected) begin
               state_d = StEmergency;
            end else if (brake_pedal) begin
               state_d = StApply;
               phase_d = 8'd0;
            end
         end
         StApply: begin
            if (Object_detected) begin
               state_d = StEmergency;
            end else if (!brake_pedal) begin
               state_d = StIdle;
            end else if (stopped) begin
               state_d = StStopped;
            end else if (slip && (phase_q >= ApplyLast)) begin
               state_d = StRelease;
               phase_d = 8'd0;
            end else if (phase_q != 8'hff) begin
               phase_d = phase_q + 8'd1;
            end
         end
         StRelease: begin
            if (Object_detected) begin
               state_d = StEmergency;
            end else if (!brake_pedal) begin
               state_d = StIdle;
            end else if (phase_q == ReleaseLast) begin
               state_d = StApply;
               phase_d = 8'd0;
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end
         StEmergency: begin
            if (!Object_detected) begin
               if (brake_pedal) begin
                  state_d = StApply;
                  phase_d = 8'd0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StStopped: begin
            if (Object_detected) begin
               state_d = StEmergency;
            end else if (!brake_pedal) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs follow the state being entered so they line up with state_o.
   always_comb begin
      brake_d  = (state_d == StApply) || (state_d == StEmergency) || (state_d == StStopped);
      active_d = active_q;
      cycles_d = cycles_q;
      if (state_d == StIdle) begin
         active_d = 1'b0;
         cycles_d = 8'd0;
      end else if ((state_d == StEmergency) || (state_d == StStopped)) begin
         active_d = 1'b0;
      end else if ((state_q == StApply) && (state_d == StRelease)) begin
         active_d = 1'b1;
         if (cycles_q != 8'hff) cycles_d = cycles_q + 8'd1;
      end
   end

   assign brake_signal = brake_q;
   assign abs_active   = active_q;
   assign abs_cycles   = cycles_q;
   assign state_o      = state_q;

endmodule
